// File: rtl/addsub_arbiter.sv
// Round-robin shares one WIDTH-bit add/subtract datapath between two valid/ready requesters.
// Results appear one cycle after acceptance; rsp_ready low holds the result and deasserts both readies.
module addsub_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_mode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_mode,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_carry
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state, state_next;
  logic             last_grant;
  logic             can_accept;
  logic             grant_vld;
  logic             grant_id;
  logic [WIDTH-1:0] sel_a, sel_b, b_eff;
  logic             sel_mode;
  logic [WIDTH:0]   full_sum;

  // Reset blocks every handshake, so a held result cannot be replaced while rst is high.
  assign can_accept = !rst && ((state == EMPTY) || rsp_ready);

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (can_accept) begin
      unique case ({req1_valid, req0_valid})
        2'b01: begin grant_vld = 1'b1; grant_id = 1'b0;        end
        2'b10: begin grant_vld = 1'b1; grant_id = 1'b1;        end
        2'b11: begin grant_vld = 1'b1; grant_id = ~last_grant; end
        default: ;
      endcase
    end
  end

  assign req0_ready = grant_vld && !grant_id;
  assign req1_ready = grant_vld &&  grant_id;

  assign sel_a    = grant_id ? req1_a    : req0_a;
  assign sel_b    = grant_id ? req1_b    : req0_b;
  assign sel_mode = grant_id ? req1_mode : req0_mode;

  // Subtract as A + ~B + 1, so carry=1 means no borrow.
  assign b_eff    = sel_b ^ {WIDTH{sel_mode}};
  assign full_sum = {1'b0, sel_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sel_mode};

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (grant_vld)
      state_next = FULL;
    else if ((state == FULL) && rsp_ready)
      state_next = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_id     <= 1'b0;
      rsp_sum    <= '0;
      rsp_carry  <= 1'b0;
      last_grant <= 1'b1;
    end else if (grant_vld) begin
      rsp_id     <= grant_id;
      rsp_sum    <= full_sum[WIDTH-1:0];
      rsp_carry  <= full_sum[WIDTH];
      last_grant <= grant_id;
    end
  end

  assign rsp_valid = (state == FULL);

endmodule
